credit_nport_switch: RTL and testbench

- Parametrised successor to the fixed three-direction credit tree switch: P ports (2 down + NUM_UP up), VC_W virtual channels, per-output credit counters held inside the block.
- Outputs are registered; arbitration is round-robin per output instead of static selection.
- Instantiated at every BFT/Pi-tree node: NUM_UP=1 gives the T topology, NUM_UP=2 gives the Pi topology.

---
 rtl/credit_nport_switch_pkg.sv | 20 ++
 rtl/credit_nport_switch_rr_arb.sv | 40 ++++
 rtl/credit_nport_switch.sv | 169 ++++++++++++++++
 tb/tb_credit_nport_switch.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_nport_switch_pkg.sv
// Shared port indices and helper functions for the credit-based n-port tree switch.
package credit_nport_switch_pkg;

  localparam int PORT_L  = 0;
  localparam int PORT_R  = 1;
  localparam int PORT_U0 = 2;

  function automatic int credit_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Local traffic descends to L/R by the address bit of this level; everything else climbs.
  function automatic int route_port(input logic [31:0] addr, input int posl, input int posx,
                                    input int in_port, input int num_up);
    if ((addr >> (posl + 1)) == $unsigned(posx))
      return addr[posl] ? PORT_R : PORT_L;
    return PORT_U0 + (in_port % num_up);
  endfunction

endpackage

// File: rtl/credit_nport_switch_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer; the pointer moves past the winner.
module credit_rr_arb #(
  parameter  int REQ_W = 4,
  localparam int IW    = (REQ_W > 1) ? $clog2(REQ_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] req,
  output logic [REQ_W-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);

  logic [IW-1:0] ptr;
  int            idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < REQ_W; i++) begin
      idx = int'(ptr) + i;
      if (idx >= REQ_W) idx = idx - REQ_W;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (|req)
      ptr <= (gnt_idx == IW'(REQ_W - 1)) ? '0 : gnt_idx + IW'(1);
  end

endmodule

// File: rtl/credit_nport_switch.sv
// P-port credit-based tree switch with per-output round-robin arbitration and registered outputs.
// Per-output flit/stall statistics are added when CREDIT_SWITCH_STATS_EN is defined.
module credit_nport_switch
  import credit_nport_switch_pkg::*;
#(
  parameter  int N             = 16,
  parameter  int A_W           = $clog2(N) + 1,
  parameter  int D_W           = 32,
  parameter  int NUM_UP        = 1,
  parameter  int VC_W          = 2,
  parameter  int VC_FIFO_DEPTH = 4,
  parameter  int posl          = 0,
  parameter  int posx          = 0,
  localparam int P             = 2 + NUM_UP,
  localparam int FW            = A_W + D_W + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [P-1:0][VC_W-1:0][FW-1:0] in_i,
  input  logic [P-1:0][VC_W-1:0]         in_i_v,
  output logic [P-1:0][VC_W-1:0]         in_i_bp,
  output logic [P-1:0][FW-1:0]           out_o,
  output logic [P-1:0][VC_W-1:0]         out_o_v,
  input  logic [P-1:0][VC_W-1:0]         out_o_credit_gnt
`ifdef CREDIT_SWITCH_STATS_EN
  ,
  output logic [P-1:0][31:0]             stat_flits,
  output logic [P-1:0][31:0]             stat_stall
`endif
);

  localparam int            REQ_W   = P * VC_W;
  localparam int            IW      = (REQ_W > 1) ? $clog2(REQ_W) : 1;
  localparam int            CW      = credit_width(VC_FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(VC_FIFO_DEPTH - 1);

  generate
    if (NUM_UP < 1 || NUM_UP > 2) begin : g_bad_num_up
      $error("credit_nport_switch: NUM_UP must be 1 or 2");
    end
    if (VC_FIFO_DEPTH < 2) begin : g_bad_depth
      $error("credit_nport_switch: VC_FIFO_DEPTH must be at least 2");
    end
  endgenerate

  int                             route [P][VC_W];
  logic [P-1:0][REQ_W-1:0]        req;
  logic [P-1:0][REQ_W-1:0]        gnt;
  logic [P-1:0][IW-1:0]           gnt_idx;
  logic [P-1:0][VC_W-1:0]         send;
  logic [P-1:0][VC_W-1:0][CW-1:0] cnt;
  logic [P-1:0][FW-1:0]           sel_flit;
  logic [P-1:0][VC_W-1:0]         sel_v;

  // A requester only competes when its target output VC still has downstream space.
  always_comb begin
    req = '0;
    for (int p = 0; p < P; p++) begin
      for (int v = 0; v < VC_W; v++) begin
        route[p][v] = route_port(32'(in_i[p][v][A_W+D_W-1:D_W]), posl, posx, p, NUM_UP);
        for (int q = 0; q < P; q++) begin
          if (in_i_v[p][v] && route[p][v] == q && q != p && cnt[q][v] != '0)
            req[q][p*VC_W+v] = 1'b1;
        end
      end
    end
  end

  for (genvar q = 0; q < P; q++) begin : g_arb
    credit_rr_arb #(.REQ_W(REQ_W)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req[q]),
      .gnt     (gnt[q]),
      .gnt_idx (gnt_idx[q])
    );
  end

  always_comb begin
    in_i_bp  = '1;
    send     = '0;
    sel_flit = '0;
    sel_v    = '0;
    for (int q = 0; q < P; q++) begin
      for (int p = 0; p < P; p++) begin
        for (int v = 0; v < VC_W; v++) begin
          if (gnt[q][p*VC_W+v]) begin
            in_i_bp[p][v] = 1'b0;
            send[q][v]    = 1'b1;
            sel_flit[q]   = in_i[p][v];
            sel_v[q][v]   = 1'b1;
          end
        end
      end
    end
  end

  // The flit register keeps its last value when idle; only the valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_o   <= '0;
      out_o_v <= '0;
    end else begin
      out_o_v <= sel_v;
      for (int q = 0; q < P; q++) begin
        if (|gnt[q]) out_o[q] <= sel_flit[q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < P; q++)
        for (int v = 0; v < VC_W; v++)
          cnt[q][v] <= CNT_MAX;
    end else begin
      for (int q = 0; q < P; q++) begin
        for (int v = 0; v < VC_W; v++) begin
          case ({send[q][v], out_o_credit_gnt[q][v]})
            2'b10:   cnt[q][v] <= cnt[q][v] - CW'(1);
            2'b01:   if (cnt[q][v] != CNT_MAX) cnt[q][v] <= cnt[q][v] + CW'(1);
            default: cnt[q][v] <= cnt[q][v];
          endcase
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int q = 0; q < P; q++) begin
        assert (gnt[q] == '0 || gnt[q][gnt_idx[q]]);
        for (int v = 0; v < VC_W; v++) begin
          assert (!(out_o_credit_gnt[q][v] && !send[q][v] && cnt[q][v] == CNT_MAX));
          assert (!(send[q][v] && cnt[q][v] == '0));
        end
      end
      for (int p = PORT_U0; p < P; p++)
        for (int v = 0; v < VC_W; v++)
          assert (!(in_i_v[p][v] && route[p][v] >= PORT_U0));
    end
  end

`ifdef CREDIT_SWITCH_STATS_EN
  logic [P-1:0] stall;

  always_comb begin
    stall = '0;
    for (int p = 0; p < P; p++)
      for (int v = 0; v < VC_W; v++)
        for (int q = 0; q < P; q++)
          if (in_i_v[p][v] && route[p][v] == q && q != p && cnt[q][v] == '0)
            stall[q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_flits <= '0;
      stat_stall <= '0;
    end else begin
      for (int q = 0; q < P; q++) begin
        if (|out_o_v[q] && stat_flits[q] != '1) stat_flits[q] <= stat_flits[q] + 32'd1;
        if (stall[q] && stat_stall[q] != '1)    stat_stall[q] <= stat_stall[q] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_credit_nport_switch.sv
// Directed self-checking bench for credit_nport_switch: a T-mode instance and a Pi-mode instance.
module tb_credit_nport_switch;

  localparam int FW = 38;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [2:0][1:0][FW-1:0] in_i;
  logic [2:0][1:0]        in_i_v, in_i_bp, credit_gnt, out_o_v;
  logic [2:0][FW-1:0]     out_o;
  logic [3:0][1:0][FW-1:0] pi_in;
  logic [3:0][1:0]        pi_in_v, pi_bp, pi_credit, pi_out_v;
  logic [3:0][FW-1:0]     pi_out;
`ifdef CREDIT_SWITCH_STATS_EN
  logic [2:0][31:0] stat_flits, stat_stall;
  logic [3:0][31:0] pi_stat_flits, pi_stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  credit_nport_switch dut (
    .clk(clk), .rst_n(rst_n), .in_i(in_i), .in_i_v(in_i_v), .in_i_bp(in_i_bp),
    .out_o(out_o), .out_o_v(out_o_v), .out_o_credit_gnt(credit_gnt)
`ifdef CREDIT_SWITCH_STATS_EN
    , .stat_flits(stat_flits), .stat_stall(stat_stall)
`endif
  );

  credit_nport_switch #(.NUM_UP(2), .posl(1), .posx(0)) dut_pi (
    .clk(clk), .rst_n(rst_n), .in_i(pi_in), .in_i_v(pi_in_v), .in_i_bp(pi_bp),
    .out_o(pi_out), .out_o_v(pi_out_v), .out_o_credit_gnt(pi_credit)
`ifdef CREDIT_SWITCH_STATS_EN
    , .stat_flits(pi_stat_flits), .stat_stall(pi_stat_stall)
`endif
  );

  function automatic logic [FW-1:0] mk_flit(input logic [4:0] addr, input logic [31:0] data);
    return {1'b1, addr, data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_i = '0; in_i_v = '0; credit_gnt = '0;
    pi_in = '0; pi_in_v = '0; pi_credit = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_inputs();
    #10;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_o_v !== '0) begin n_fail++; $display("[TB] FAIL reset_out_v: got %b expected 0", out_o_v); end
    n_checks++;
    if (out_o !== '0) begin n_fail++; $display("[TB] FAIL reset_out: got %h expected 0", out_o); end
    n_checks++;
    if (in_i_bp !== 6'b111111) begin n_fail++; $display("[TB] FAIL reset_bp: got %b expected 111111", in_i_bp); end
    for (int q = 0; q < 3; q++)
      for (int v = 0; v < 2; v++) begin
        n_checks++;
        if (dut.cnt[q][v] !== 2'd3) begin
          n_fail++; $display("[TB] FAIL reset_cnt[%0d][%0d]: got %0d expected 3", q, v, dut.cnt[q][v]);
        end
      end
  endtask

  task automatic test_single_flit();
    logic [FW-1:0] f;
    do_reset();
    f = mk_flit(5'd1, 32'hA5A5_0001);
    in_i[0][0] = f; in_i_v[0][0] = 1'b1;
    #4;
    n_checks++;
    if (in_i_bp !== 6'b111110) begin n_fail++; $display("[TB] FAIL single_bp: got %b expected 111110", in_i_bp); end
    tick();
    in_i_v = '0;
    n_checks++;
    if (out_o_v !== 6'b000100) begin n_fail++; $display("[TB] FAIL single_out_v: got %b expected 000100", out_o_v); end
    n_checks++;
    if (out_o[1] !== f) begin n_fail++; $display("[TB] FAIL single_payload: got %h expected %h", out_o[1], f); end
    tick();
    n_checks++;
    if (out_o_v !== '0) begin n_fail++; $display("[TB] FAIL single_idle_v: got %b expected 0", out_o_v); end
    n_checks++;
    if (out_o[1] !== f) begin n_fail++; $display("[TB] FAIL single_hold: got %h expected %h", out_o[1], f); end
  endtask

  task automatic test_route_up_concurrent();
    logic [FW-1:0] fu, fl;
    do_reset();
    fu = mk_flit(5'd6, 32'h0000_00C1);
    fl = mk_flit(5'd0, 32'h0000_00C2);
    in_i[0][1] = fu; in_i_v[0][1] = 1'b1;
    in_i[1][0] = fl; in_i_v[1][0] = 1'b1;
    #4;
    n_checks++;
    if (in_i_bp !== 6'b111001) begin n_fail++; $display("[TB] FAIL conc_bp: got %b expected 111001", in_i_bp); end
    tick();
    in_i_v = '0;
    n_checks++;
    if (out_o_v !== 6'b100001) begin n_fail++; $display("[TB] FAIL conc_out_v: got %b expected 100001", out_o_v); end
    n_checks++;
    if (out_o[2] !== fu) begin n_fail++; $display("[TB] FAIL conc_up_payload: got %h expected %h", out_o[2], fu); end
    n_checks++;
    if (out_o[0] !== fl) begin n_fail++; $display("[TB] FAIL conc_l_payload: got %h expected %h", out_o[0], fl); end
  endtask

  task automatic test_credit_exhaustion();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_i[0][1] = mk_flit(5'd1, 32'h0000_0E00 + k); in_i_v[0][1] = 1'b1;
      #4;
      n_checks++;
      if (in_i_bp[0][1] !== (k >= 3)) begin
        n_fail++; $display("[TB] FAIL exhaust_bp k=%0d: got %b expected %b", k, in_i_bp[0][1], (k >= 3));
      end
      tick();
      n_checks++;
      if (out_o_v[1] !== ((k < 3) ? 2'b10 : 2'b00)) begin
        n_fail++; $display("[TB] FAIL exhaust_out_v k=%0d: got %b", k, out_o_v[1]);
      end
      if (k < 3) begin
        n_checks++;
        if (out_o[1] !== mk_flit(5'd1, 32'h0000_0E00 + k)) begin
          n_fail++; $display("[TB] FAIL exhaust_payload k=%0d: got %h", k, out_o[1]);
        end
      end
    end
    credit_gnt[1][1] = 1'b1;
    #4;
    n_checks++;
    if (in_i_bp[0][1] !== 1'b1) begin n_fail++; $display("[TB] FAIL exhaust_held: got %b expected 1", in_i_bp[0][1]); end
    tick();
    credit_gnt = '0;
    #4;
    n_checks++;
    if (in_i_bp[0][1] !== 1'b0) begin n_fail++; $display("[TB] FAIL exhaust_release_bp: got %b expected 0", in_i_bp[0][1]); end
    tick();
    in_i_v = '0;
    n_checks++;
    if (out_o_v[1] !== 2'b10 || out_o[1] !== mk_flit(5'd1, 32'h0000_0E03)) begin
      n_fail++; $display("[TB] FAIL exhaust_release_out: got v=%b d=%h", out_o_v[1], out_o[1]);
    end
  endtask

  task automatic test_round_robin();
    logic [FW-1:0] fl, fu, fexp;
    do_reset();
    fl = mk_flit(5'd1, 32'h0000_AAAA);
    fu = mk_flit(5'd1, 32'h0000_BBBB);
    in_i[0][0] = fl; in_i_v[0][0] = 1'b1;
    in_i[2][0] = fu; in_i_v[2][0] = 1'b1;
    credit_gnt[1][0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #4;
      n_checks++;
      if (in_i_bp[0][0] !== (i % 2 == 1) || in_i_bp[2][0] !== (i % 2 == 0)) begin
        n_fail++; $display("[TB] FAIL rr_bp i=%0d: got L=%b U0=%b", i, in_i_bp[0][0], in_i_bp[2][0]);
      end
      tick();
      fexp = (i % 2 == 0) ? fl : fu;
      n_checks++;
      if (out_o_v[1] !== 2'b01 || out_o[1] !== fexp) begin
        n_fail++; $display("[TB] FAIL rr_out i=%0d: got v=%b d=%h expected d=%h", i, out_o_v[1], out_o[1], fexp);
      end
    end
    clear_inputs();
    n_checks++;
    if (dut.cnt[1][0] !== 2'd3) begin n_fail++; $display("[TB] FAIL rr_cnt: got %0d expected 3", dut.cnt[1][0]); end
  endtask

  task automatic test_send_and_credit();
    do_reset();
    in_i[0][0] = mk_flit(5'd1, 32'h0000_5000); in_i_v[0][0] = 1'b1;
    tick();
    tick();
    n_checks++;
    if (dut.cnt[1][0] !== 2'd1) begin n_fail++; $display("[TB] FAIL sc_pre_cnt: got %0d expected 1", dut.cnt[1][0]); end
    credit_gnt[1][0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_i[0][0] = mk_flit(5'd1, 32'h0000_5100 + i);
      #4;
      n_checks++;
      if (in_i_bp[0][0] !== 1'b0) begin n_fail++; $display("[TB] FAIL sc_bp i=%0d: got %b expected 0", i, in_i_bp[0][0]); end
      tick();
      n_checks++;
      if (out_o_v[1] !== 2'b01 || out_o[1] !== mk_flit(5'd1, 32'h0000_5100 + i) || dut.cnt[1][0] !== 2'd1) begin
        n_fail++; $display("[TB] FAIL sc_flow i=%0d: got v=%b d=%h cnt=%0d expected cnt 1", i, out_o_v[1], out_o[1], dut.cnt[1][0]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_pi_mode();
    logic [FW-1:0] f0, f1;
    do_reset();
    f0 = mk_flit(5'd8, 32'h0000_7001);
    f1 = mk_flit(5'd9, 32'h0000_7002);
    pi_in[0][0] = f0; pi_in_v[0][0] = 1'b1;
    pi_in[1][1] = f1; pi_in_v[1][1] = 1'b1;
    #4;
    n_checks++;
    if (pi_bp !== 8'b11110110) begin n_fail++; $display("[TB] FAIL pi_bp: got %b expected 11110110", pi_bp); end
    tick();
    pi_in_v = '0;
    n_checks++;
    if (pi_out_v !== 8'b10010000) begin n_fail++; $display("[TB] FAIL pi_out_v: got %b expected 10010000", pi_out_v); end
    n_checks++;
    if (pi_out[2] !== f0 || pi_out[3] !== f1) begin
      n_fail++; $display("[TB] FAIL pi_payload: got U0=%h U1=%h expected %h %h", pi_out[2], pi_out[3], f0, f1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_i[0][0] = mk_flit(5'd1, 32'h0000_9000); in_i_v[0][0] = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_o_v[1] !== 2'b01) begin n_fail++; $display("[TB] FAIL areset_pre_v: got %b expected 01", out_o_v[1]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_o_v !== '0 || out_o !== '0) begin
      n_fail++; $display("[TB] FAIL areset_out: got v=%b d=%h expected 0", out_o_v, out_o);
    end
    clear_inputs();
    #13;
    rst_n = 1'b1;
    #1;
    for (int q = 0; q < 3; q++)
      for (int v = 0; v < 2; v++) begin
        n_checks++;
        if (dut.cnt[q][v] !== 2'd3) begin
          n_fail++; $display("[TB] FAIL areset_cnt[%0d][%0d]: got %0d expected 3", q, v, dut.cnt[q][v]);
        end
      end
    tick();
    n_checks++;
    if (out_o_v !== '0) begin n_fail++; $display("[TB] FAIL areset_post_v: got %b expected 0", out_o_v); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_flit();
    test_route_up_concurrent();
    test_credit_exhaustion();
    test_round_robin();
    test_send_and_credit();
    test_pi_mode();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
